// File: rtl/memory_responder_if.sv
// Core-side memory bus plus console drain port for memory_responder.
// The core (master) issues re/we strobes; the responder (slave) returns dataout and drives the console.
interface memory_responder_if;
    logic        re;
    logic        we;
    logic [31:0] addr;
    logic [31:0] datain;
    logic [31:0] dataout;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    modport master (
        output re, we, addr, datain, tx_ready,
        input  dataout, tx_data, tx_valid
    );

    modport slave (
        input  re, we, addr, datain, tx_ready,
        output dataout, tx_data, tx_valid
    );
endinterface

// File: rtl/memory_responder.sv
// Word RAM plus MMIO window (console FIFO, halt/exit, cycle counter) for the multicycle RV32I core.
// Optional feature macro: MEMORY_RESPONDER_CYCLE_COUNTER_EN adds the CYCLE counter register.
module memory_responder #(
    parameter int          MEM_WORDS  = 4096,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] MMIO_BASE  = 32'hFFFF_FFF0
) (
    input  logic                clock,
    input  logic                reset,
    memory_responder_if.slave   bus,
    output logic                halted,
    output logic [31:0]         exit_code,
    output logic                bus_err
);
    localparam int AW = $clog2(MEM_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);

    logic [31:0] mem [MEM_WORDS];
    logic [7:0]  fifo_mem [FIFO_DEPTH];
    logic [PW:0] rd_ptr;
    logic [PW:0] wr_ptr;
    logic        ovf;
    logic [31:0] cycle_val;
    logic [31:0] rdata;

    logic [AW-1:0] ram_idx;
    logic [1:0]    reg_sel;
    logic          in_ram;
    logic          in_mmio;
    logic          wr_ok;
    logic          push_req;
    logic          push;
    logic          pop;
    logic          halt_wr;
    logic          fifo_empty;
    logic          fifo_full;

    assign ram_idx  = bus.addr[AW+1:2];
    assign reg_sel  = bus.addr[3:2];
    assign in_ram   = bus.addr[31:2] < 30'(MEM_WORDS);
    assign in_mmio  = bus.addr[31:4] == MMIO_BASE[31:4];
    assign wr_ok    = bus.we && !halted;
    assign push_req = wr_ok && in_mmio && (reg_sel == 2'd0);
    assign halt_wr  = wr_ok && in_mmio && (reg_sel == 2'd1);

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign pop        = !fifo_empty && bus.tx_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push       = push_req && (!fifo_full || pop);

    assign bus.tx_valid = !fifo_empty;
    assign bus.tx_data  = fifo_mem[rd_ptr[PW-1:0]];

    always_ff @(posedge clock) begin
        if (wr_ok && in_ram && !reset)
            mem[ram_idx] <= bus.datain;
    end

    always_ff @(posedge clock) begin
        if (push && !reset)
            fifo_mem[wr_ptr[PW-1:0]] <= bus.datain[7:0];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + (PW+1)'(1);
            if (pop)
                rd_ptr <= rd_ptr + (PW+1)'(1);
            if (push_req && fifo_full && !pop)
                ovf <= 1'b1;
        end
    end

`ifdef MEMORY_RESPONDER_CYCLE_COUNTER_EN
    logic [31:0] cycle_cnt;

    always_ff @(posedge clock) begin
        if (reset)
            cycle_cnt <= '0;
        else if (!halted)
            cycle_cnt <= cycle_cnt + 32'd1;
    end

    assign cycle_val = cycle_cnt;
`else
    assign cycle_val = 32'h0;
`endif

    always_comb begin
        rdata = 32'h0;
        if (in_ram) begin
            rdata = mem[ram_idx];
        end else if (in_mmio) begin
            case (reg_sel)
                2'd0:    rdata = {29'b0, ovf, fifo_empty, fifo_full};
                2'd1:    rdata = exit_code;
                2'd2:    rdata = cycle_val;
                default: rdata = 32'h0;
            endcase
        end
    end

    // Status registers; the read sees pre-edge state, giving read-before-write on re&&we.
    always_ff @(posedge clock) begin
        if (reset) begin
            bus.dataout <= 32'h0;
            halted      <= 1'b0;
            exit_code   <= 32'h0;
            bus_err     <= 1'b0;
        end else begin
            if (bus.re)
                bus.dataout <= rdata;
            if (halt_wr) begin
                halted    <= 1'b1;
                exit_code <= bus.datain;
            end
            if ((bus.re || wr_ok) && !in_ram && !in_mmio)
                bus_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_memory_responder.sv
// Directed self-checking bench for memory_responder: RAM, console FIFO, halt, bus error, reset.
module tb_memory_responder;
    localparam logic [31:0] CONSOLE = 32'hFFFF_FFF0;
    localparam logic [31:0] HALT    = 32'hFFFF_FFF4;
    localparam logic [31:0] CYCLE   = 32'hFFFF_FFF8;
    localparam logic [31:0] RSVD    = 32'hFFFF_FFFC;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        halted;
    logic [31:0] exit_code;
    logic        bus_err;
    int          tests_run = 0;
    int          tests_failed = 0;
    logic [31:0] tb_cycles = 32'h0;
    logic [31:0] frozen_cnt;

    memory_responder_if bus ();

    memory_responder #(
        .MEM_WORDS (4096),
        .FIFO_DEPTH(8),
        .MMIO_BASE (32'hFFFF_FFF0)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .bus      (bus),
        .halted   (halted),
        .exit_code(exit_code),
        .bus_err  (bus_err)
    );

    always #5 clock = ~clock;

    // Independent count of edges since reset, used as the cycle-counter reference.
    always @(posedge clock) begin
        if (reset)
            tb_cycles <= 32'h0;
        else
            tb_cycles <= tb_cycles + 32'd1;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        bus.re     = r;
        bus.we     = w;
        bus.addr   = a;
        bus.datain = d;
        @(posedge clock);
        #1;
        bus.re = 1'b0;
        bus.we = 1'b0;
    endtask

    task automatic resetDut();
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic drainExpect(input logic [7:0] first, input int n);
        bus.tx_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            checkOutput($sformatf("drain_valid_%0d", i), {31'b0, bus.tx_valid}, 32'h1);
            checkOutput($sformatf("drain_data_%0d", i), {24'b0, bus.tx_data}, {24'b0, first + 8'(i)});
            applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        end
        checkOutput("drain_empty", {31'b0, bus.tx_valid}, 32'h0);
        bus.tx_ready = 1'b0;
    endtask

    initial begin
        bus.re = 1'b0;
        bus.we = 1'b0;
        bus.addr = 32'h0;
        bus.datain = 32'h0;
        bus.tx_ready = 1'b0;
        @(posedge clock);
        #1;
        resetDut();

        checkOutput("rst_dataout", bus.dataout, 32'h0);
        checkOutput("rst_tx_valid", {31'b0, bus.tx_valid}, 32'h0);
        checkOutput("rst_halted", {31'b0, halted}, 32'h0);
        checkOutput("rst_exit_code", exit_code, 32'h0);
        checkOutput("rst_bus_err", {31'b0, bus_err}, 32'h0);

        applyStimulus(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
        applyStimulus(1'b1, 1'b0, 32'h0000_0013, 32'h0);
        checkOutput("ram_rd_after_wr", bus.dataout, 32'hDEAD_BEEF);

        applyStimulus(1'b0, 1'b1, 32'h0000_0020, 32'h1);
        applyStimulus(1'b1, 1'b1, 32'h0000_0020, 32'h2);
        checkOutput("rmw_old", bus.dataout, 32'h1);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("dataout_hold", bus.dataout, 32'h1);
        applyStimulus(1'b1, 1'b0, 32'h0000_0020, 32'h0);
        checkOutput("rmw_new", bus.dataout, 32'h2);
        applyStimulus(1'b0, 1'b1, 32'h0000_0000, 32'h1234_5678);

        for (int i = 0; i < 9; i++)
            applyStimulus(1'b0, 1'b1, CONSOLE, 32'h41 + i);
        checkOutput("fifo_head", {24'b0, bus.tx_data}, 32'h41);
        applyStimulus(1'b1, 1'b0, CONSOLE, 32'h0);
        checkOutput("status_full_ovf", bus.dataout, 32'h5);
        drainExpect(8'h41, 8);
        applyStimulus(1'b1, 1'b0, CONSOLE, 32'h0);
        checkOutput("status_empty_ovf", bus.dataout, 32'h6);

        for (int i = 0; i < 8; i++)
            applyStimulus(1'b0, 1'b1, CONSOLE, 32'h50 + i);
        bus.tx_ready = 1'b1;
        applyStimulus(1'b0, 1'b1, CONSOLE, 32'h58);
        bus.tx_ready = 1'b0;
        drainExpect(8'h51, 8);

        applyStimulus(1'b1, 1'b0, 32'h8000_0000, 32'h0);
        checkOutput("err_rd_zero", bus.dataout, 32'h0);
        checkOutput("err_set", {31'b0, bus_err}, 32'h1);
        applyStimulus(1'b1, 1'b0, 32'h0000_0010, 32'h0);
        checkOutput("err_sticky", {31'b0, bus_err}, 32'h1);
        checkOutput("ram_after_err", bus.dataout, 32'hDEAD_BEEF);

        frozen_cnt = tb_cycles + 32'd1;
        applyStimulus(1'b0, 1'b1, HALT, 32'h2A);
        checkOutput("halted_set", {31'b0, halted}, 32'h1);
        checkOutput("exit_code", exit_code, 32'h2A);
        applyStimulus(1'b0, 1'b1, 32'h0000_0000, 32'h5);
        applyStimulus(1'b0, 1'b1, HALT, 32'h99);
        applyStimulus(1'b0, 1'b1, CONSOLE, 32'h60);
        checkOutput("halt_no_push", {31'b0, bus.tx_valid}, 32'h0);
        checkOutput("halt_exit_kept", exit_code, 32'h2A);
        applyStimulus(1'b1, 1'b0, 32'h0000_0000, 32'h0);
        checkOutput("halt_ram_kept", bus.dataout, 32'h1234_5678);
        applyStimulus(1'b1, 1'b0, HALT, 32'h0);
        checkOutput("halt_reg_rd", bus.dataout, 32'h2A);
`ifdef MEMORY_RESPONDER_CYCLE_COUNTER_EN
        applyStimulus(1'b1, 1'b0, CYCLE, 32'h0);
        checkOutput("cycle_frozen_1", bus.dataout, frozen_cnt);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        applyStimulus(1'b1, 1'b0, CYCLE, 32'h0);
        checkOutput("cycle_frozen_2", bus.dataout, frozen_cnt);
`else
        applyStimulus(1'b1, 1'b0, CYCLE, 32'h0);
        checkOutput("cycle_absent", bus.dataout, 32'h0);
`endif
        applyStimulus(1'b1, 1'b0, RSVD, 32'h0);
        checkOutput("rsvd_rd", bus.dataout, 32'h0);

        resetDut();
        checkOutput("unhalt", {31'b0, halted}, 32'h0);
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b0, 1'b1, CONSOLE, 32'h70 + i);
        checkOutput("queued", {31'b0, bus.tx_valid}, 32'h1);
        bus.we = 1'b1;
        bus.addr = 32'h0000_0010;
        bus.datain = 32'h0000_0BAD;
        resetDut();
        bus.we = 1'b0;
        checkOutput("mid_rst_tx_valid", {31'b0, bus.tx_valid}, 32'h0);
        checkOutput("mid_rst_halted", {31'b0, halted}, 32'h0);
        checkOutput("mid_rst_bus_err", {31'b0, bus_err}, 32'h0);
        checkOutput("mid_rst_dataout", bus.dataout, 32'h0);
        applyStimulus(1'b1, 1'b0, CYCLE, 32'h0);
        checkOutput("cycle_restart", bus.dataout, 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h0000_0010, 32'h0);
        checkOutput("rst_drops_write", bus.dataout, 32'hDEAD_BEEF);
        applyStimulus(1'b1, 1'b0, CYCLE, 32'h0);
`ifdef MEMORY_RESPONDER_CYCLE_COUNTER_EN
        checkOutput("cycle_counting", bus.dataout, 32'h2);
`else
        checkOutput("cycle_counting", bus.dataout, 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
